traffic_mode_ctrl: RTL and testbench
====================================

TRAFFIC_MODE_CTRL -- requirements
Module: traffic_mode_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1: clk cycles per one-second tick.
REQ-002 The block SHALL have parameter CLEAR_TIME, default 2: all-red clearance length in ticks.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous reset, active-low.
REQ-005 The block SHALL have port mode_req, input, 2 bits: requested mode (0 AUTO, 1 MANUAL, 2 FLASH, 3 reserved).
REQ-006 The block SHALL have port mode_valid, input, 1 bit: mode_req is sampled when this is high.
REQ-007 The block SHALL have port manual_step, input, 1 bit: advance request while in MANUAL.
REQ-008 The block SHALL have ports cfg_wr (1 bit), cfg_sel (2 bits: 0 green, 1 yellow, 2 red) and cfg_data (7 bits), all inputs: timing write.
REQ-009 The block SHALL have outputs cfg_ack and cfg_err, 1 bit each: write accepted or rejected.
REQ-010 The block SHALL have port auto_state, input, 3 bits: phase from the timer datapath (GR=3, YR=4, RG=5, RY=6).
REQ-011 The block SHALL have outputs auto_enable (1 bit) and green_time, yellow_time, red_time (7 bits each): these drive the timer datapath.
REQ-012 The block SHALL have outputs light1 and light2, 2 bits each (0 off, 1 red, 2 yellow, 3 green), plus mode, 2 bits: current mode.
REQ-013 The block SHALL have output busy, 1 bit: high while in CLEAR.

Function
REQ-014 The top FSM SHALL have states CLEAR, AUTO, MANUAL and FLASH, plus a 2-bit target register.
REQ-015 A tick counter SHALL count 0..TICK_DIV-1 and pulse tick for one cycle at wrap; it SHALL reset to 0 on every FSM state change.
REQ-016 mode_valid with a mode_req differing from the current mode SHALL load target and move to CLEAR on the next edge.
REQ-017 mode_valid with mode_req equal to the current mode, or with mode_req=3, SHALL be ignored.
REQ-018 mode_valid while in CLEAR SHALL update target only; the clearance count SHALL NOT restart.
REQ-019 CLEAR SHALL drive both lights red and busy=1, and SHALL exit to target after exactly CLEAR_TIME ticks.
REQ-020 In AUTO, auto_enable SHALL be 1; auto_enable SHALL drop in the same edge the FSM leaves AUTO.
REQ-021 In AUTO, lights SHALL decode from auto_state: GR=(green,red), YR=(yellow,red), RG=(red,green), RY=(red,yellow), any other value=(red,red).
REQ-022 MANUAL SHALL keep an internal phase that is set to GR on entry.
REQ-023 In MANUAL, manual_step in GR SHALL move the phase to YR, and manual_step in RG SHALL move it to RY.
REQ-024 A yellow phase in MANUAL SHALL last yellow_time ticks, then advance automatically (YR->RG, RY->GR); manual_step during yellow SHALL be ignored.
REQ-025 FLASH SHALL drive both lights yellow on entry, then toggle yellow/off on each tick.
REQ-026 cfg_wr SHALL be accepted only when mode is not AUTO and cfg_data is in 1..99 and cfg_sel is not 3.
REQ-027 An accepted write SHALL update the selected register and pulse cfg_ack for one cycle after the write; any other write SHALL pulse cfg_err instead and leave the registers unchanged.
REQ-028 Simultaneous mode_valid and cfg_wr SHALL both be processed; the cfg check SHALL use the mode before the edge.

Reset
REQ-029 While reset=0 at an edge, the block SHALL load state=CLEAR, target=AUTO, mode=AUTO (reported), busy=1, auto_enable=0.
REQ-030 Reset SHALL also load both lights red, green_time=30, yellow_time=3, red_time=33, cfg_ack=0, cfg_err=0, and clear all counters.
REQ-031 Reset asserted mid-operation (any state or mid-write) SHALL override all other inputs on that edge.

Structure
REQ-032 Phase codes (GR/YR/RG/RY), mode codes, light codes and the default timings SHALL live in shared package traffic_pkg.
REQ-033 The tick generator SHALL be a sub-module named tick_gen (parameter TICK_DIV, ports clk/reset/clr/tick).

Verification (TICK_DIV=1, CLEAR_TIME=2)
REQ-034 Release reset -> busy=1 and lights (red,red) for 2 cycles, then auto_enable=1 and mode=AUTO.
REQ-035 In AUTO, drive auto_state=4 -> lights (yellow,red); then pulse mode_valid with mode_req=1 -> auto_enable=0 next edge, 2 clearance cycles, then MANUAL with lights (green,red).
REQ-036 In MANUAL, set yellow_time=3, then pulse manual_step -> (yellow,red) for 3 cycles, then (red,green).
REQ-037 In AUTO, cfg_wr green=40 -> cfg_err pulse and green_time stays 30; in MANUAL, cfg_data=0 -> cfg_err; cfg_data=45 -> cfg_ack and green_time=45.
REQ-038 In CLEAR with target MANUAL, pulse mode_valid with mode_req=2 one cycle in -> exit to FLASH after the original 2 ticks; lights then alternate yellow/off each cycle.
REQ-039 Pull reset low during a MANUAL yellow phase -> next edge all reset values per REQ-029/REQ-030.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared codes and default timings for the intersection mode controller.
package traffic_pkg;

    // Mode codes as seen on mode_req and mode
    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_MANUAL = 2'd1;
    localparam logic [1:0] MODE_FLASH  = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    // Phase codes shared with the timer datapath (first road / second road)
    localparam logic [2:0] PH_GR = 3'd3;
    localparam logic [2:0] PH_YR = 3'd4;
    localparam logic [2:0] PH_RG = 3'd5;
    localparam logic [2:0] PH_RY = 3'd6;

    // Lamp codes driven on light1 / light2
    localparam logic [1:0] LIGHT_OFF    = 2'd0;
    localparam logic [1:0] LIGHT_RED    = 2'd1;
    localparam logic [1:0] LIGHT_YELLOW = 2'd2;
    localparam logic [1:0] LIGHT_GREEN  = 2'd3;

    // Timing register selectors on cfg_sel
    localparam logic [1:0] CFG_GREEN  = 2'd0;
    localparam logic [1:0] CFG_YELLOW = 2'd1;
    localparam logic [1:0] CFG_RED    = 2'd2;
    localparam logic [1:0] CFG_RSVD   = 2'd3;

    // Power-on timings in ticks, and the legal range for a timing write
    localparam logic [6:0] DEF_GREEN  = 7'd30;
    localparam logic [6:0] DEF_YELLOW = 7'd3;
    localparam logic [6:0] DEF_RED    = 7'd33;
    localparam logic [6:0] CFG_MIN    = 7'd1;
    localparam logic [6:0] CFG_MAX    = 7'd99;

    // Lamp pair for both roads
    typedef struct packed {
        logic [1:0] l1;
        logic [1:0] l2;
    } light_pair_t;

    // Build a lamp pair from two lamp codes
    function automatic light_pair_t make_pair(input logic [1:0] a, input logic [1:0] b);
        light_pair_t p;
        p.l1 = a;
        p.l2 = b;
        return p;
    endfunction

    // Decode a phase code into lamps; anything unknown falls back to all red
    function automatic light_pair_t phase_lights(input logic [2:0] phase);
        light_pair_t p;
        case (phase)
            PH_GR:   p = make_pair(LIGHT_GREEN,  LIGHT_RED);
            PH_YR:   p = make_pair(LIGHT_YELLOW, LIGHT_RED);
            PH_RG:   p = make_pair(LIGHT_RED,    LIGHT_GREEN);
            PH_RY:   p = make_pair(LIGHT_RED,    LIGHT_YELLOW);
            default: p = make_pair(LIGHT_RED,    LIGHT_RED);
        endcase
        return p;
    endfunction

    // True when a timing value is inside the writable range
    function automatic logic cfg_data_ok(input logic [6:0] data);
        return (data >= CFG_MIN) && (data <= CFG_MAX);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: divides clk down to a one-cycle tick every TICK_DIV cycles.
module tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Divider count, restarted by clr so every new state begins on a full tick period
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_mode_ctrl.sv
// traffic_mode_ctrl: selects AUTO / MANUAL / FLASH operation with an all-red
// clearance between modes, owns the phase timing registers and drives the lamps.
module traffic_mode_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int CLEAR_TIME = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_req,
    input  logic       mode_valid,
    input  logic       manual_step,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_sel,
    input  logic [6:0] cfg_data,
    output logic       cfg_ack,
    output logic       cfg_err,
    input  logic [2:0] auto_state,
    output logic       auto_enable,
    output logic [6:0] green_time,
    output logic [6:0] yellow_time,
    output logic [6:0] red_time,
    output logic [1:0] light1,
    output logic [1:0] light2,
    output logic [1:0] mode,
    output logic       busy
);

    // Operating state codes equal the mode codes, so leaving CLEAR is a direct copy of target
    localparam logic [1:0] S_AUTO   = 2'd0;
    localparam logic [1:0] S_MANUAL = 2'd1;
    localparam logic [1:0] S_FLASH  = 2'd2;
    localparam logic [1:0] S_CLEAR  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [1:0]  target;
    logic [1:0]  target_nxt;
    logic [1:0]  mode_q;
    logic        tick;
    logic        state_chg;
    logic        req_ok;
    logic        clear_done;
    logic [15:0] clear_cnt;
    logic [2:0]  man_phase;
    logic [6:0]  yel_cnt;
    logic        yel_done;
    logic        flash_on;
    logic        cfg_accept;
    light_pair_t lamps;

    assign state_chg = (state_nxt != state);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (state_chg),
        .tick  (tick)
    );

    // A request carrying the reserved code is dropped everywhere
    assign req_ok     = mode_valid && (mode_req != MODE_RSVD);
    assign clear_done = tick && ((clear_cnt + 16'd1) >= 16'(CLEAR_TIME));

    // Next state and target: requests in CLEAR only retarget, elsewhere a different mode starts a clearance
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        if (state == S_CLEAR) begin
            if (req_ok) begin
                target_nxt = mode_req;
            end
            if (clear_done) begin
                state_nxt = target_nxt;
            end
        end else if (req_ok && (mode_req != mode_q)) begin
            target_nxt = mode_req;
            state_nxt  = S_CLEAR;
        end
    end

    // State, target and reported mode; the reported mode only changes when a clearance completes
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_CLEAR;
            target <= MODE_AUTO;
            mode_q <= MODE_AUTO;
        end else begin
            state  <= state_nxt;
            target <= target_nxt;
            if ((state == S_CLEAR) && (state_nxt != S_CLEAR)) begin
                mode_q <= target_nxt;
            end
        end
    end

    // Clearance tick count; held at zero outside CLEAR so every clearance starts fresh
    always_ff @(posedge clk) begin
        if (!reset) begin
            clear_cnt <= '0;
        end else if (state != S_CLEAR) begin
            clear_cnt <= '0;
        end else if (tick) begin
            clear_cnt <= clear_cnt + 16'd1;
        end
    end

    assign yel_done = tick && ((yel_cnt + 7'd1) >= yellow_time);

    // Manual phase sequencer: steps leave green, yellow times out on its own
    always_ff @(posedge clk) begin
        if (!reset) begin
            man_phase <= PH_GR;
            yel_cnt   <= '0;
        end else if (state != S_MANUAL) begin
            man_phase <= PH_GR;
            yel_cnt   <= '0;
        end else begin
            case (man_phase)
                PH_GR: begin
                    if (manual_step) begin
                        man_phase <= PH_YR;
                        yel_cnt   <= '0;
                    end
                end
                PH_RG: begin
                    if (manual_step) begin
                        man_phase <= PH_RY;
                        yel_cnt   <= '0;
                    end
                end
                PH_YR, PH_RY: begin
                    if (yel_done) begin
                        man_phase <= (man_phase == PH_YR) ? PH_RG : PH_GR;
                        yel_cnt   <= '0;
                    end else if (tick) begin
                        yel_cnt <= yel_cnt + 7'd1;
                    end
                end
                default: begin
                    man_phase <= PH_GR;
                    yel_cnt   <= '0;
                end
            endcase
        end
    end

    // Flash blinker: starts lit on entry and toggles once per tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            flash_on <= 1'b1;
        end else if (state != S_FLASH) begin
            flash_on <= 1'b1;
        end else if (tick) begin
            flash_on <= ~flash_on;
        end
    end

    // Timing writes are refused while the timer datapath is running them in AUTO
    assign cfg_accept = (mode_q != MODE_AUTO) && cfg_data_ok(cfg_data) && (cfg_sel != CFG_RSVD);

    // Timing registers and the one-cycle ack/err response
    always_ff @(posedge clk) begin
        if (!reset) begin
            green_time  <= DEF_GREEN;
            yellow_time <= DEF_YELLOW;
            red_time    <= DEF_RED;
            cfg_ack     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_wr) begin
                if (cfg_accept) begin
                    case (cfg_sel)
                        CFG_GREEN:  green_time  <= cfg_data;
                        CFG_YELLOW: yellow_time <= cfg_data;
                        CFG_RED:    red_time    <= cfg_data;
                        default:    ;
                    endcase
                    cfg_ack <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    // Lamp selection per state; CLEAR and anything unexpected show all red
    always_comb begin
        lamps = make_pair(LIGHT_RED, LIGHT_RED);
        case (state)
            S_AUTO:   lamps = phase_lights(auto_state);
            S_MANUAL: lamps = phase_lights(man_phase);
            S_FLASH:  lamps = flash_on ? make_pair(LIGHT_YELLOW, LIGHT_YELLOW)
                                       : make_pair(LIGHT_OFF, LIGHT_OFF);
            default:  lamps = make_pair(LIGHT_RED, LIGHT_RED);
        endcase
    end

    assign light1      = lamps.l1;
    assign light2      = lamps.l2;
    assign mode        = mode_q;
    assign busy        = (state == S_CLEAR);
    assign auto_enable = (state == S_AUTO);

endmodule

// File: tb/tb_traffic_mode_ctrl.sv
// tb_traffic_mode_ctrl: directed walk through the mode scenarios followed by
// random traffic, every cycle compared against a behavioural model.
`timescale 1ns/1ps
module tb_traffic_mode_ctrl;

    localparam int CLEAR_TICKS = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode_req;
    logic       mode_valid;
    logic       manual_step;
    logic       cfg_wr;
    logic [1:0] cfg_sel;
    logic [6:0] cfg_data;
    logic       cfg_ack;
    logic       cfg_err;
    logic [2:0] auto_state;
    logic       auto_enable;
    logic [6:0] green_time;
    logic [6:0] yellow_time;
    logic [6:0] red_time;
    logic [1:0] light1;
    logic [1:0] light2;
    logic [1:0] mode;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: mode 0 auto / 1 manual / 2 flash; manual phase 0 GR, 1 YR, 2 RG, 3 RY
    int mLive = 0;
    int mInClear, mClearLeft, mTarget, mMode;
    int mGreen, mYellow, mRed, mAck, mErr;
    int mPhase, mYelDone, mFlashOn;

    traffic_mode_ctrl #(
        .TICK_DIV   (1),
        .CLEAR_TIME (CLEAR_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_req    (mode_req),
        .mode_valid  (mode_valid),
        .manual_step (manual_step),
        .cfg_wr      (cfg_wr),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .cfg_ack     (cfg_ack),
        .cfg_err     (cfg_err),
        .auto_state  (auto_state),
        .auto_enable (auto_enable),
        .green_time  (green_time),
        .yellow_time (yellow_time),
        .red_time    (red_time),
        .light1      (light1),
        .light2      (light2),
        .mode        (mode),
        .busy        (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mLive      = 1;
        mInClear   = 1;
        mClearLeft = CLEAR_TICKS;
        mTarget    = 0;
        mMode      = 0;
        mGreen     = 30;
        mYellow    = 3;
        mRed       = 33;
        mAck       = 0;
        mErr       = 0;
        mPhase     = 0;
        mYelDone   = 0;
        mFlashOn   = 1;
    endtask

    // Lamp codes: 0 off, 1 red, 2 yellow, 3 green
    task automatic expectLights(input int as, output int e1, output int e2);
        int ph;
        e1 = 1;
        e2 = 1;
        ph = -1;
        if (mInClear == 0 && mMode == 0) begin
            if (as >= 3 && as <= 6) ph = as - 3;
        end else if (mInClear == 0 && mMode == 1) begin
            ph = mPhase;
        end else if (mInClear == 0 && mMode == 2) begin
            e1 = mFlashOn ? 2 : 0;
            e2 = e1;
        end
        case (ph)
            0: begin e1 = 3; e2 = 1; end
            1: begin e1 = 2; e2 = 1; end
            2: begin e1 = 1; e2 = 3; end
            3: begin e1 = 1; e2 = 2; end
            default: ;
        endcase
    endtask

    task automatic checkAll();
        int e1, e2;
        expectLights(int'(auto_state), e1, e2);
        checkOutput("light1", int'(light1), e1);
        checkOutput("light2", int'(light2), e2);
        checkOutput("mode", int'(mode), mMode);
        checkOutput("busy", int'(busy), mInClear);
        checkOutput("auto_enable", int'(auto_enable), (mInClear == 0 && mMode == 0) ? 1 : 0);
        checkOutput("green_time", int'(green_time), mGreen);
        checkOutput("yellow_time", int'(yellow_time), mYellow);
        checkOutput("red_time", int'(red_time), mRed);
        checkOutput("cfg_ack", int'(cfg_ack), mAck);
        checkOutput("cfg_err", int'(cfg_err), mErr);
    endtask

    // One clock edge of the behavioural model
    task automatic modelStep(input bit rst, input bit mv, input int mr, input bit ms,
                             input bit cw, input int cs, input int cd);
        int oldYellow, oldMode;
        if (!rst) begin
            modelReset();
            return;
        end
        oldYellow = mYellow;
        oldMode   = mMode;
        mAck = 0;
        mErr = 0;
        if (cw) begin
            if (oldMode != 0 && cd >= 1 && cd <= 99 && cs != 3) begin
                if (cs == 0) mGreen = cd;
                if (cs == 1) mYellow = cd;
                if (cs == 2) mRed = cd;
                mAck = 1;
            end else begin
                mErr = 1;
            end
        end
        if (mInClear != 0) begin
            if (mv && mr != 3) mTarget = mr;
            mClearLeft--;
            if (mClearLeft <= 0) begin
                mInClear = 0;
                mMode    = mTarget;
                mPhase   = 0;
                mYelDone = 0;
                mFlashOn = 1;
            end
        end else if (mv && mr != 3 && mr != mMode) begin
            mInClear   = 1;
            mClearLeft = CLEAR_TICKS;
            mTarget    = mr;
        end else if (mMode == 1) begin
            if ((mPhase == 0 || mPhase == 2) && ms) begin
                mPhase   = mPhase + 1;
                mYelDone = 0;
            end else if (mPhase == 1 || mPhase == 3) begin
                mYelDone++;
                if (mYelDone >= oldYellow) begin
                    mPhase   = (mPhase + 1) % 4;
                    mYelDone = 0;
                end
            end
        end else if (mMode == 2) begin
            mFlashOn = mFlashOn ? 0 : 1;
        end
    endtask

    // Drive one cycle of inputs, check outputs before the edge, then advance the model
    task automatic applyStimulus(input bit rst, input bit mv, input int mr, input bit ms,
                                 input bit cw, input int cs, input int cd, input int as);
        @(negedge clk);
        reset       = rst;
        mode_valid  = mv;
        mode_req    = 2'(mr);
        manual_step = ms;
        cfg_wr      = cw;
        cfg_sel     = 2'(cs);
        cfg_data    = 7'(cd);
        auto_state  = 3'(as);
        #1;
        if (mLive != 0) checkAll();
        @(posedge clk);
        modelStep(rst, mv, mr, ms, cw, cs, cd);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 4);
    endtask

    initial begin
        reset       = 1'b0;
        mode_valid  = 1'b0;
        mode_req    = 2'd0;
        manual_step = 1'b0;
        cfg_wr      = 1'b0;
        cfg_sel     = 2'd0;
        cfg_data    = 7'd0;
        auto_state  = 3'd0;

        // Reset and power-on values
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 3);
        #1;
        checkOutput("rst_busy", int'(busy), 1);
        checkOutput("rst_auto_en", int'(auto_enable), 0);
        checkOutput("rst_light1", int'(light1), 1);
        checkOutput("rst_light2", int'(light2), 1);
        checkOutput("rst_green", int'(green_time), 30);
        checkOutput("rst_yellow", int'(yellow_time), 3);
        checkOutput("rst_red", int'(red_time), 33);

        // Clearance after reset, then AUTO with a refused timing write
        idle(2);
        applyStimulus(1, 0, 0, 0, 1, 0, 40, 4);
        #1;
        checkOutput("auto_yellow_l1", int'(light1), 2);
        checkOutput("auto_cfg_err", int'(cfg_err), 1);
        checkOutput("auto_green_kept", int'(green_time), 30);

        // Switch to MANUAL
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 4);
        #1;
        checkOutput("leave_auto_en", int'(auto_enable), 0);
        idle(2);
        #1;
        checkOutput("manual_l1", int'(light1), 3);
        checkOutput("manual_mode", int'(mode), 1);

        // Timing writes in MANUAL
        applyStimulus(1, 0, 0, 0, 1, 1, 3, 4);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 4);
        #1;
        checkOutput("zero_cfg_err", int'(cfg_err), 1);
        applyStimulus(1, 0, 0, 0, 1, 0, 45, 4);
        #1;
        checkOutput("cfg_ack_45", int'(cfg_ack), 1);
        checkOutput("green_45", int'(green_time), 45);

        // Manual step: three yellow ticks then the cross road goes green
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 4);
        #1;
        checkOutput("step_l1_yellow", int'(light1), 2);
        idle(3);
        #1;
        checkOutput("after_yellow_l2", int'(light2), 3);

        // Retarget during a clearance: AUTO -> (MANUAL retargeted to FLASH)
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 4);
        idle(2);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 4);
        applyStimulus(1, 1, 2, 0, 0, 0, 0, 4);
        idle(1);
        #1;
        checkOutput("flash_mode", int'(mode), 2);
        checkOutput("flash_on_l1", int'(light1), 2);
        idle(1);
        #1;
        checkOutput("flash_off_l1", int'(light1), 0);
        idle(2);

        // Reset in the middle of a manual yellow, with other inputs active
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 4);
        idle(2);
        applyStimulus(1, 0, 0, 0, 1, 1, 5, 4);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 4);
        idle(1);
        applyStimulus(0, 1, 2, 1, 1, 0, 50, 4);
        #1;
        checkOutput("midrst_busy", int'(busy), 1);
        checkOutput("midrst_mode", int'(mode), 0);
        checkOutput("midrst_yellow", int'(yellow_time), 3);
        checkOutput("midrst_green", int'(green_time), 30);
        checkOutput("midrst_ack", int'(cfg_ack), 0);
        checkOutput("midrst_l1", int'(light1), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 9) == 0),
                          int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0),
                          int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 127)),
                          int'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
